// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store memory controller.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DEFAULT_MEM_WORDS = 4096;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WRITE,
    S_RESP
  } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] wdata_rep;
  logic [3:0]  byte_en;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = rdata;
    endcase
  end

  // Store data is replicated across lanes so each byte lane just picks old or new.
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        wdata_rep = {4{wdata[7:0]}};
        byte_en   = 4'b0001 << offset;
      end
      2'b01: begin
        wdata_rep = {2{wdata[15:0]}};
        byte_en   = offset[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_rep = wdata;
        byte_en   = 4'b1111;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[gi*8 +: 8] = byte_en[gi] ? wdata_rep[gi*8 +: 8] : rdata[gi*8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for the word-addressed RAM data port, with RMW for SB/SH.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses error instead of being aligned down.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = DEFAULT_MEM_WORDS,
  parameter int WORD_AW   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  state_t state_reg, state_next;

  logic               we_reg;
  logic [2:0]         funct3_reg;
  logic [1:0]         offset_reg;
  logic [31:0]        wdata_reg;
  logic [WORD_AW-1:0] mem_addr_reg;
  logic               err_reg;
  logic [31:0]        rdata_reg;
  logic [31:0]        merge_reg;

  logic               f3_ok;
  logic               misaligned;
  logic               out_of_range;
  logic               req_bad;
  logic [1:0]         offset_eff;
  logic [31:0]        word_idx;
  logic [31:0]        load_data;
  logic [31:0]        merged_word;
  logic               accept;

  assign accept   = (state_reg == S_IDLE) && req_valid;
  assign word_idx = {2'b00, req_addr[31:2]};

  // Request checks evaluated on the accept cycle.
  always_comb begin
    case (req_funct3)
      F3_B, F3_H, F3_W: f3_ok = 1'b1;
      F3_BU, F3_HU:     f3_ok = !req_we;
      default:          f3_ok = 1'b0;
    endcase
    out_of_range = word_idx >= 32'(MEM_WORDS);
  end

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    offset_eff = req_addr[1:0];
  end
`else
  // Without the trap, low address bits are forced to natural alignment.
  always_comb begin
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   offset_eff = {req_addr[1], 1'b0};
      2'b10:   offset_eff = 2'b00;
      default: offset_eff = req_addr[1:0];
    endcase
  end
`endif

  assign req_bad = !f3_ok || misaligned || out_of_range;

  lsu_lane_align u_lane_align (
    .funct3      (funct3_reg),
    .offset      (offset_reg),
    .rdata       (mem_rdata),
    .wdata       (wdata_reg),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      we_reg       <= 1'b0;
      funct3_reg   <= 3'd0;
      offset_reg   <= 2'd0;
      wdata_reg    <= 32'd0;
      mem_addr_reg <= '0;
      err_reg      <= 1'b0;
      rdata_reg    <= 32'd0;
      merge_reg    <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        we_reg       <= req_we;
        funct3_reg   <= req_funct3;
        offset_reg   <= offset_eff;
        wdata_reg    <= req_wdata;
        mem_addr_reg <= req_addr[WORD_AW+1:2];
        err_reg      <= req_bad;
        rdata_reg    <= 32'd0;
      end
      if (state_reg == S_ACCESS) begin
        if (!we_reg) rdata_reg <= load_data;
        merge_reg <= merged_word;
      end
    end
  end

  // Write strobe is masked by rst so a reset cycle never commits a store.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = 32'd0;
    case (state_reg)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_bad ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        if (we_reg && (funct3_reg == F3_W)) begin
          mem_we     = !rst;
          mem_wdata  = wdata_reg;
          state_next = S_RESP;
        end else if (we_reg) begin
          state_next = S_WRITE;
        end else begin
          state_next = S_RESP;
        end
      end
      S_WRITE: begin
        mem_we     = !rst;
        mem_wdata  = merge_reg;
        state_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign mem_addr   = {{(32-WORD_AW){1'b0}}, mem_addr_reg};
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: vector table plus stall and reset-during-RMW sequences.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  logic [31:0] ram [0:4095];
  logic        pre_en = 1'b0;
  logic [11:0] pre_idx = 12'd0;
  logic [31:0] pre_data = 32'd0;

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr[11:0]];

  always @(posedge clk) begin
    if (pre_en) ram[pre_idx] <= pre_data;
    else if (mem_we) ram[mem_addr[11:0]] <= mem_wdata;
  end

  always @(posedge clk) if (mem_we) we_cnt <= we_cnt + 1;

  lsu_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err,
                     input int exp_lat, input int exp_we);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_we = exp_we;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [11:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_data = data;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int we0;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    we0 = we_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(lat);
    chk({v.name, " rdata"}, resp_rdata, v.exp_rdata);
    chk({v.name, " err"}, 32'(resp_err), 32'(v.exp_err));
    chk({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({v.name, " we_pulses"}, 32'(we_cnt - we0), 32'(v.exp_we));
    $display("txn %-12s we=%0d f3=%0d addr=%h -> rdata=%h err=%0d lat=%0d",
             v.name, v.we, v.f3, v.addr, resp_rdata, resp_err, lat);
    @(posedge clk); #1;
    chk({v.name, " idle_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int we0;

    add("sw_10",    1'b1, F3_W,  32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 2, 1);
    add("lw_10",    1'b0, F3_W,  32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 2, 0);
    add("sb_11",    1'b1, F3_B,  32'h11,   32'h0000005A, 32'h0,        1'b0, 3, 1);
    add("lbu_11",   1'b0, F3_BU, 32'h11,   32'h0,        32'h0000005A, 1'b0, 2, 0);
    add("lw_10b",   1'b0, F3_W,  32'h10,   32'h0,        32'hDEAD5AEF, 1'b0, 2, 0);
    add("lb_20",    1'b0, F3_B,  32'h20,   32'h0,        32'hFFFFFFFF, 1'b0, 2, 0);
    add("lh_22",    1'b0, F3_H,  32'h22,   32'h0,        32'hFFFF8000, 1'b0, 2, 0);
    add("lhu_22",   1'b0, F3_HU, 32'h22,   32'h0,        32'h00008000, 1'b0, 2, 0);
`ifdef MISALIGN_TRAP_EN
    add("lh_21",    1'b0, F3_H,  32'h21,   32'h0,        32'h0,        1'b1, 1, 0);
    add("lw_13",    1'b0, F3_W,  32'h13,   32'h0,        32'h0,        1'b1, 1, 0);
`else
    add("lh_21",    1'b0, F3_H,  32'h21,   32'h0,        32'hFFFFF0FF, 1'b0, 2, 0);
    add("lw_13",    1'b0, F3_W,  32'h13,   32'h0,        32'hDEAD5AEF, 1'b0, 2, 0);
`endif
    add("lw_4000",  1'b0, F3_W,  32'h4000, 32'h0,        32'h0,        1'b1, 1, 0);
    add("sw_4000",  1'b1, F3_W,  32'h4000, 32'h12345678, 32'h0,        1'b1, 1, 0);
    add("ld_f3_3",  1'b0, 3'b011, 32'h20,  32'h0,        32'h0,        1'b1, 1, 0);
    add("st_f3_4",  1'b1, F3_BU, 32'h20,   32'h000000AA, 32'h0,        1'b1, 1, 0);
    add("sh_22",    1'b1, F3_H,  32'h22,   32'hFFFF1234, 32'h0,        1'b0, 3, 1);
    add("lw_20",    1'b0, F3_W,  32'h20,   32'h0,        32'h1234F0FF, 1'b0, 2, 0);
    add("lb_21",    1'b0, F3_B,  32'h21,   32'h0,        32'hFFFFFFF0, 1'b0, 2, 0);
    add("sw_3ffc",  1'b1, F3_W,  32'h3FFC, 32'hCAFEF00D, 32'h0,        1'b0, 2, 1);
    add("lw_3ffc",  1'b0, F3_W,  32'h3FFC, 32'h0,        32'hCAFEF00D, 1'b0, 2, 0);
    add("sb_3",     1'b1, F3_B,  32'h3,    32'hFFFFFF80, 32'h0,        1'b0, 3, 1);
    add("lw_0",     1'b0, F3_W,  32'h0,    32'h0,        32'h80000000, 1'b0, 2, 0);
    add("lhu_2",    1'b0, F3_HU, 32'h2,    32'h0,        32'h00008000, 1'b0, 2, 0);

    // Reset state, with RAM preload done while reset is held.
    preload(12'd0,    32'h0);
    preload(12'd4,    32'h0);
    preload(12'd8,    32'h8000F0FF);
    preload(12'd16,   32'h11223344);
    preload(12'd4095, 32'h0);
    chk("rst req_ready",  32'(req_ready),  32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_rdata", resp_rdata,      32'd0);
    chk("rst resp_err",   32'(resp_err),   32'd0);
    chk("rst mem_we",     32'(mem_we),     32'd0);
    chk("rst mem_addr",   mem_addr,        32'd0);
    chk("rst mem_wdata",  mem_wdata,       32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Response stall: outputs must hold and no new request may be taken.
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_funct3 = F3_BU; req_addr = 32'h11;
    wait_resp(lat);
    chk("stall latency", 32'(lat), 32'd2);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("stall resp_valid", 32'(resp_valid), 32'd1);
      chk("stall resp_rdata", resp_rdata,      32'hDEAD5AEF);
      chk("stall resp_err",   32'(resp_err),   32'd0);
      chk("stall req_ready",  32'(req_ready),  32'd0);
    end
    $display("txn stall        lw 0x10 held 5 cycles rdata=%h", resp_rdata);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("handshake resp_valid", 32'(resp_valid), 32'd0);
    chk("handshake req_ready",  32'(req_ready),  32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b accepted", 32'(req_ready), 32'd0);
    wait_resp(lat);
    chk("b2b rdata",   resp_rdata, 32'h0000005A);
    chk("b2b latency", 32'(lat),   32'd2);
    $display("txn b2b          lbu 0x11 rdata=%h lat=%0d", resp_rdata, lat);
    @(posedge clk); #1;

    // Reset while the SH write is on the port: memory must stay untouched.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_H; req_addr = 32'h40; req_wdata = 32'h0000BEEF;
    we0 = we_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rmw write mem_we",    32'(mem_we), 32'd1);
    chk("rmw write mem_addr",  mem_addr,    32'd16);
    chk("rmw write mem_wdata", mem_wdata,   32'h1122BEEF);
    rst = 1'b1;
    #1;
    chk("rmw rst mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rmw rst req_ready",  32'(req_ready),      32'd1);
    chk("rmw rst resp_valid", 32'(resp_valid),     32'd0);
    chk("rmw rst mem_we",     32'(mem_we),         32'd0);
    chk("rmw rst word",       ram[16],             32'h11223344);
    chk("rmw rst we_pulses",  32'(we_cnt - we0),   32'd0);
    $display("txn rst_in_write sh 0x40 abandoned word=%h", ram[16]);

    begin
      vec_t v;
      v.name = "lw_40"; v.we = 1'b0; v.f3 = F3_W; v.addr = 32'h40; v.wdata = 32'h0;
      v.exp_rdata = 32'h11223344; v.exp_err = 1'b0; v.exp_lat = 2; v.exp_we = 0;
      run_vec(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store initiator that drives the data port of the unified 16 KB word-addressed RAM on behalf of the core's memory stage. Accepts byte-addressed RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) over a valid/ready handshake. Converts them to word accesses, performing read-modify-write for sub-word stores because the RAM writes whole words only. Returns sign- or zero-extended load data on a valid/ready response channel.

Parameters:
MEM_WORDS, 4096, RAM depth in 32-bit words; word index at or above this is out of range.
WORD_AW, 12, width of the word index driven to the RAM; equals clog2(MEM_WORDS).

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  input  32  byte address
req_wdata  input  32  store data; low bits used for B/H
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  32  extended load data; 0 for stores
resp_err  output  1  misaligned, out-of-range or illegal funct3
mem_addr  output  32  word index to RAM data port (zero-extended WORD_AW bits)
mem_wdata  output  32  word to write
mem_we  output  1  RAM write enable, sampled on posedge clk
mem_rdata  input  32  combinational RAM read of mem_addr

Behaviour:
- States: IDLE, ACCESS, WRITE, RESP.
- Reset: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_we=0; mem_addr=0; mem_wdata=0.
- IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata and go to ACCESS; else stay.
- Checks at accept: illegal funct3 (011, 110, 111; loads with 1xx also legal only for 100/101; stores only 000/001/010); halfword with addr[0]=1; word with addr[1:0]!=0; word index addr[31:2] >= MEM_WORDS. Any failure: skip memory, next state RESP with resp_err=1, resp_rdata=0.
- ACCESS (1 cycle): mem_addr=addr[31:2].
  - Load: capture mem_rdata, extract lane, sign/zero extend; go to RESP.
  - SW: mem_we=1, mem_wdata=wdata; go to RESP.
  - SB/SH: merge wdata lane(s) into mem_rdata at byte offset addr[1:0] and register it; go to WRITE.
- WRITE (SB/SH only): mem_we=1, mem_addr held, mem_wdata = merged word; go to RESP.
- RESP: resp_valid=1, outputs stable until resp_ready; on resp_ready go to IDLE. req_ready=0 outside IDLE, so no request can be accepted in the same cycle as a response handshake.
- Latency, accept to resp_valid: loads and SW take 2 cycles. SB/SH take 3 cycles. Error responses take 1 cycle.
- mem_we is 0 in every state except SW-ACCESS and WRITE, and asserts for exactly one cycle per store.
- Lane rules: byte lane = addr[1:0]*8. Halfword lane = addr[1]*16. Little-endian.
- Reset mid-operation: abandon the access and return to IDLE. A write is never issued after the reset cycle; a partial RMW leaves memory unchanged.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: misaligned H/W accesses return resp_err=1 with no memory access, as above.
- Undefined: no misalignment error. Low address bits are forced to natural alignment (H clears bit 0, W clears bits 1:0) and the access proceeds. Range and funct3 checks still apply.

Decomposition:
- Package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum type, MEM_WORDS default.
- Sub-module lsu_lane_align (combinational): load extract/extend and store merge from funct3, byte offset and data. Unit-testable on its own.

Test Plan:
- SW 0xDEADBEEF at byte addr 0x10, then LW 0x10 -> mem_we pulse with mem_addr=4; load resp_rdata=0xDEADBEEF, resp_err=0, 2-cycle latency each.
- Word 0x10=0xDEADBEEF; SB 0x5A at 0x11 -> read then write 0xDEAD5AEF, 3-cycle latency; LBU 0x11 -> 0x0000005A.
- Word 0x20=0x8000F0FF; LB 0x20 -> 0xFFFFFFFF; LH 0x22 -> 0xFFFF8000; LHU 0x22 -> 0x00008000.
- LW at 0x4000 (index 4096) -> resp_err=1, no mem_we, 1-cycle latency. With MISALIGN_TRAP_EN: LH at 0x21 -> resp_err=1. Without it: LH at 0x21 reads lane 0x20.
- Hold resp_ready=0 for 5 cycles -> resp_valid, resp_rdata and resp_err stable, req_ready=0. Back-to-back req_valid accepted only after the handshake.
- Assert rst during SH WRITE state -> next cycle IDLE, mem_we=0, target word unchanged.
